// File: rtl/stopwatch_pkg.sv
// Shared types and helpers for the BCD up/down stopwatch.
// Holds the control FSM encoding, BCD digit constants and the digit clamp.
package stopwatch_pkg;

    localparam int unsigned BCD_W = 4;
    localparam logic [BCD_W-1:0] BCD_MAX = 4'd9;

    typedef enum logic [1:0] {
        StStop  = 2'd0,
        StRun   = 2'd1,
        StClear = 2'd2
    } state_e;

    function automatic logic [BCD_W-1:0] bcd_clamp(input logic [BCD_W-1:0] digit);
        return (digit > BCD_MAX) ? BCD_MAX : digit;
    endfunction

endpackage

// File: rtl/tick_gen.sv
// Prescaler: counts 0..DIV-1 while enabled and holds while disabled.
// o_tick is combinational, high during the cycle whose edge wraps the count.
module tick_gen #(
    parameter int unsigned DIV = 10
) (
    input  logic clk,
    input  logic reset,
    input  logic en,
    input  logic clr,
    output logic o_tick
);

    localparam int unsigned CntW = (DIV > 2) ? $clog2(DIV) : 1;
    localparam logic [CntW-1:0] CntMax = CntW'(DIV - 1);

    logic [CntW-1:0] cnt_q, cnt_d;
    logic            wrap;

    assign wrap   = en && !clr && (cnt_q == CntMax);
    assign o_tick = wrap;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = wrap ? '0 : cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/bcd_updown_stopwatch.sv
// Multi-digit BCD up/down counter with prescaler and run/stop/clear control.
// Wraps or saturates at the terminal value; preload is accepted only while stopped.
module bcd_updown_stopwatch
    import stopwatch_pkg::*;
#(
    parameter int unsigned CLK_HZ     = 100_000_000,
    parameter int unsigned TICK_HZ    = 10,
    parameter int unsigned NUM_DIGITS = 4,
    parameter bit          WRAP       = 1'b1
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          i_run,
    input  logic                          i_clear,
    input  logic                          i_dir,
    input  logic                          i_load,
    input  logic [BCD_W*NUM_DIGITS-1:0]   i_load_val,
    output logic [BCD_W*NUM_DIGITS-1:0]   o_bcd,
    output logic                          o_tick,
    output logic                          o_carry,
    output logic                          o_running,
    output logic [1:0]                    o_state
);

    localparam int unsigned DIV = CLK_HZ / TICK_HZ;
    localparam int unsigned W   = BCD_W * NUM_DIGITS;

    if (DIV < 2) begin : g_bad_div
        $error("bcd_updown_stopwatch: CLK_HZ/TICK_HZ must be at least 2");
    end
    if (NUM_DIGITS < 1 || NUM_DIGITS > 8) begin : g_bad_digits
        $error("bcd_updown_stopwatch: NUM_DIGITS must be within 1..8");
    end

    state_e                state_q;
    logic                  running_q;
    logic [W-1:0]          bcd_q;
    logic                  tick_q;
    logic                  carry_q;

    logic                  clr;
    logic                  tick_now;
    logic                  terminal;
    logic [W-1:0]          next_cnt;
    logic [W-1:0]          load_clamped;
    logic [NUM_DIGITS-1:0] is9;
    logic [NUM_DIGITS-1:0] is0;
    logic [NUM_DIGITS-1:0] carry;

    // Clearing starts on the edge that enters CLEAR, so a clear request wins over load.
    assign clr = i_clear || (state_q == StClear);

    tick_gen #(
        .DIV (DIV)
    ) u_tick_gen (
        .clk    (clk),
        .reset  (reset),
        .en     (state_q == StRun),
        .clr    (clr),
        .o_tick (tick_now)
    );

    for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_digit
        localparam logic [NUM_DIGITS-1:0] LowMask = NUM_DIGITS'((1 << g) - 1);

        logic [BCD_W-1:0] d;
        logic             cin;

        assign d      = bcd_q[g*BCD_W +: BCD_W];
        assign is9[g] = (d == BCD_MAX);
        assign is0[g] = (d == '0);

        // Carry/borrow into this digit: every lower digit sits at its terminal value.
        assign cin      = i_dir ? &(is0 | ~LowMask) : &(is9 | ~LowMask);
        assign carry[g] = cin & (i_dir ? is0[g] : is9[g]);

        assign next_cnt[g*BCD_W +: BCD_W] =
            !cin  ? d :
            i_dir ? (is0[g] ? BCD_MAX : d - 4'd1) :
                    (is9[g] ? 4'd0    : d + 4'd1);

        assign load_clamped[g*BCD_W +: BCD_W] = bcd_clamp(i_load_val[g*BCD_W +: BCD_W]);
    end

    // The top carry can only be set when every lower carry is, so AND-ing them is exact.
    assign terminal = &carry;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= StStop;
            running_q <= 1'b0;
        end else if (i_clear) begin
            state_q   <= StClear;
            running_q <= 1'b0;
        end else begin
            case (state_q)
                StStop: begin
                    state_q   <= i_run ? StRun : StStop;
                    running_q <= i_run;
                end
                StRun: begin
                    state_q   <= i_run ? StRun : StStop;
                    running_q <= i_run;
                end
                default: begin
                    state_q   <= StStop;
                    running_q <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bcd_q   <= '0;
            tick_q  <= 1'b0;
            carry_q <= 1'b0;
        end else if (clr) begin
            bcd_q   <= '0;
            tick_q  <= 1'b0;
            carry_q <= 1'b0;
        end else begin
            tick_q  <= tick_now;
            carry_q <= tick_now & terminal;
            if (state_q == StStop && i_load) begin
                bcd_q <= load_clamped;
            end else if (tick_now && (WRAP || !terminal)) begin
                bcd_q <= next_cnt;
            end
        end
    end

    assign o_bcd     = bcd_q;
    assign o_tick    = tick_q;
    assign o_carry   = carry_q;
    assign o_running = running_q;
    assign o_state   = state_q;

endmodule

// File: tb/tb_bcd_updown_stopwatch.sv
// Bench for bcd_updown_stopwatch: wrapping and saturating instances driven in parallel,
// directed scenarios followed by random stimulus, checked against a decimal-arithmetic model.
module tb_bcd_updown_stopwatch;

    localparam int unsigned ClkHz     = 100;
    localparam int unsigned TickHz    = 10;
    localparam int unsigned NumDigits = 4;
    localparam int          Div       = ClkHz / TickHz;
    localparam int          MaxVal    = 9999;

    logic        clk;
    logic        reset;
    logic        i_run, i_clear, i_dir, i_load;
    logic [15:0] i_load_val;

    logic [15:0] bcd_w, bcd_s;
    logic        tick_w, tick_s, carry_w, carry_s, run_w, run_s;
    logic [1:0]  state_w, state_s;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: state as 0=stop 1=run 2=clear, count as a plain decimal integer.
    int m_state, m_pre, m_val, m_sval;
    bit m_tick, m_carry, m_scarry;

    bcd_updown_stopwatch #(
        .CLK_HZ     (ClkHz),
        .TICK_HZ    (TickHz),
        .NUM_DIGITS (NumDigits),
        .WRAP       (1'b1)
    ) u_dut_wrap (
        .clk        (clk),
        .reset      (reset),
        .i_run      (i_run),
        .i_clear    (i_clear),
        .i_dir      (i_dir),
        .i_load     (i_load),
        .i_load_val (i_load_val),
        .o_bcd      (bcd_w),
        .o_tick     (tick_w),
        .o_carry    (carry_w),
        .o_running  (run_w),
        .o_state    (state_w)
    );

    bcd_updown_stopwatch #(
        .CLK_HZ     (ClkHz),
        .TICK_HZ    (TickHz),
        .NUM_DIGITS (NumDigits),
        .WRAP       (1'b0)
    ) u_dut_sat (
        .clk        (clk),
        .reset      (reset),
        .i_run      (i_run),
        .i_clear    (i_clear),
        .i_dir      (i_dir),
        .i_load     (i_load),
        .i_load_val (i_load_val),
        .o_bcd      (bcd_s),
        .o_tick     (tick_s),
        .o_carry    (carry_s),
        .o_running  (run_s),
        .o_state    (state_s)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
        end
    endtask

    function automatic logic [15:0] to_bcd(input int v);
        logic [15:0] r;
        int p;
        r = '0;
        p = 1;
        for (int i = 0; i < 4; i++) begin
            r[4*i +: 4] = 4'((v / p) % 10);
            p = p * 10;
        end
        return r;
    endfunction

    function automatic int from_bcd_clamp(input logic [15:0] b);
        int v, p, n;
        v = 0;
        p = 1;
        for (int i = 0; i < 4; i++) begin
            n = int'(b[4*i +: 4]);
            if (n > 9) n = 9;
            v = v + n * p;
            p = p * 10;
        end
        return v;
    endfunction

    function automatic int step_val(input int v, input bit down);
        return down ? (v + MaxVal) % (MaxVal + 1) : (v + 1) % (MaxVal + 1);
    endfunction

    task automatic model_reset();
        m_state  = 0;
        m_pre    = 0;
        m_val    = 0;
        m_sval   = 0;
        m_tick   = 1'b0;
        m_carry  = 1'b0;
        m_scarry = 1'b0;
    endtask

    // Advance the model by one clock edge using the inputs currently applied.
    task automatic model_step();
        int  ns, npre, nval, nsval;
        bit  clr, tk, term_w, term_s;
        clr = i_clear || (m_state == 2);
        if (i_clear)          ns = 2;
        else if (m_state < 2) ns = i_run ? 1 : 0;
        else                  ns = 0;
        tk     = (m_state == 1) && (m_pre == Div - 1) && !clr;
        term_w = i_dir ? (m_val == 0)  : (m_val == MaxVal);
        term_s = i_dir ? (m_sval == 0) : (m_sval == MaxVal);
        if (clr)               npre = 0;
        else if (m_state == 1) npre = tk ? 0 : m_pre + 1;
        else                   npre = m_pre;
        nval  = m_val;
        nsval = m_sval;
        if (clr) begin
            nval  = 0;
            nsval = 0;
        end else if (m_state == 0 && i_load) begin
            nval  = from_bcd_clamp(i_load_val);
            nsval = nval;
        end else if (tk) begin
            nval = step_val(m_val, i_dir);
            if (!term_s) nsval = step_val(m_sval, i_dir);
        end
        m_state  = ns;
        m_pre    = npre;
        m_val    = nval;
        m_sval   = nsval;
        m_tick   = tk;
        m_carry  = tk && term_w;
        m_scarry = tk && term_s;
    endtask

    task automatic compare_all();
        check_eq("bcd_wrap",    32'(bcd_w),   32'(to_bcd(m_val)));
        check_eq("bcd_sat",     32'(bcd_s),   32'(to_bcd(m_sval)));
        check_eq("tick_wrap",   32'(tick_w),  32'(m_tick));
        check_eq("tick_sat",    32'(tick_s),  32'(m_tick));
        check_eq("carry_wrap",  32'(carry_w), 32'(m_carry));
        check_eq("carry_sat",   32'(carry_s), 32'(m_scarry));
        check_eq("running",     32'(run_w),   32'(m_state == 1));
        check_eq("running_sat", 32'(run_s),   32'(m_state == 1));
        check_eq("state",       32'(state_w), 32'(m_state));
        check_eq("state_sat",   32'(state_s), 32'(m_state));
    endtask

    task automatic cycle();
        model_step();
        @(posedge clk);
        #1;
        compare_all();
    endtask

    task automatic run_until_tick(input string tag, output int waited);
        bit seen;
        seen   = 1'b0;
        waited = 0;
        for (int k = 0; k < 40 && !seen; k++) begin
            cycle();
            waited++;
            if (tick_w) seen = 1'b1;
        end
        check_eq({tag, "_seen"}, 32'(seen), 32'd1);
    endtask

    task automatic load_stopped(input logic [15:0] val);
        i_run = 1'b0;
        cycle();
        i_load     = 1'b1;
        i_load_val = val;
        cycle();
        i_load = 1'b0;
    endtask

    initial begin
        int ticks, last, rise, tc, waited, carries;

        reset      = 1'b0;
        i_run      = 1'b0;
        i_clear    = 1'b0;
        i_dir      = 1'b0;
        i_load     = 1'b0;
        i_load_val = '0;
        #2 reset = 1'b1;
        #1;
        check_eq("rst_bcd",     32'(bcd_w),   32'h0);
        check_eq("rst_state",   32'(state_w), 32'd0);
        check_eq("rst_running", 32'(run_w),   32'd0);
        check_eq("rst_tick",    32'(tick_w),  32'd0);
        check_eq("rst_carry",   32'(carry_w), 32'd0);
        model_reset();
        @(posedge clk);
        #1;
        reset = 1'b0;

        // 1: free run from reset
        i_run = 1'b1;
        ticks = 0;
        last  = -1;
        for (int c = 1; c <= 35; c++) begin
            cycle();
            if (tick_w) begin
                if (last >= 0) check_eq("t1_gap", 32'(c - last), 32'(Div));
                last = c;
                ticks++;
            end
        end
        check_eq("t1_ticks",   32'(ticks), 32'd3);
        check_eq("t1_bcd",     32'(bcd_w), 32'h0003);
        check_eq("t1_running", 32'(run_w), 32'd1);

        // 2: pause keeps the prescaler phase
        i_clear = 1'b1;
        cycle();
        check_eq("t2_clear_state", 32'(state_w), 32'd2);
        i_clear = 1'b0;
        i_run   = 1'b0;
        cycle();
        i_run = 1'b1;
        repeat (15) cycle();
        i_run = 1'b0;
        repeat (50) cycle();
        check_eq("t2_hold_bcd", 32'(bcd_w), 32'h0001);
        check_eq("t2_stopped",  32'(run_w), 32'd0);
        i_run = 1'b1;
        rise  = -1;
        tc    = -1;
        for (int c = 1; c <= 30 && tc < 0; c++) begin
            cycle();
            if (run_w && rise < 0) rise = c;
            if (tick_w) tc = c;
        end
        check_eq("t2_resume_gap", 32'(tc - rise), 32'd5);

        // 3: wrap up and down
        load_stopped(16'h9998);
        check_eq("t3_load", 32'(bcd_w), 32'h9998);
        i_dir = 1'b0;
        i_run = 1'b1;
        run_until_tick("t3_up1", waited);
        check_eq("t3_up1_bcd",   32'(bcd_w),   32'h9999);
        check_eq("t3_up1_carry", 32'(carry_w), 32'd0);
        run_until_tick("t3_up2", waited);
        check_eq("t3_up2_bcd",   32'(bcd_w),   32'h0000);
        check_eq("t3_up2_carry", 32'(carry_w), 32'd1);
        load_stopped(16'h0001);
        i_dir = 1'b1;
        i_run = 1'b1;
        run_until_tick("t3_dn1", waited);
        check_eq("t3_dn1_bcd",   32'(bcd_w),   32'h0000);
        check_eq("t3_dn1_carry", 32'(carry_w), 32'd0);
        run_until_tick("t3_dn2", waited);
        check_eq("t3_dn2_bcd",   32'(bcd_w),   32'h9999);
        check_eq("t3_dn2_carry", 32'(carry_w), 32'd1);

        // 4: saturation on the WRAP=0 instance
        load_stopped(16'h9999);
        i_dir   = 1'b0;
        i_run   = 1'b1;
        ticks   = 0;
        carries = 0;
        for (int t = 0; t < 3; t++) begin
            run_until_tick("t4", waited);
            if (tick_s)  ticks++;
            if (carry_s) carries++;
            check_eq("t4_bcd_sat", 32'(bcd_s), 32'h9999);
        end
        check_eq("t4_ticks",   32'(ticks),   32'd3);
        check_eq("t4_carries", 32'(carries), 32'd3);

        // 5: clear has priority, then one STOP cycle, then a full period
        load_stopped(16'h0042);
        i_run = 1'b1;
        repeat (3) cycle();
        i_clear = 1'b1;
        cycle();
        check_eq("t5_state_clear", 32'(state_w), 32'd2);
        check_eq("t5_bcd_zero",    32'(bcd_w),   32'h0);
        i_clear = 1'b0;
        cycle();
        check_eq("t5_state_stop", 32'(state_w), 32'd0);
        cycle();
        check_eq("t5_state_run", 32'(state_w), 32'd1);
        run_until_tick("t5_first", waited);
        check_eq("t5_first_tick", 32'(waited), 32'(Div));

        // 6: clamp on load, load ignored in RUN, async reset mid-count
        load_stopped(16'h12A7);
        check_eq("t6_clamp",     32'(bcd_w), 32'h1297);
        check_eq("t6_clamp_sat", 32'(bcd_s), 32'h1297);
        i_run = 1'b1;
        cycle();
        i_load     = 1'b1;
        i_load_val = 16'h5555;
        repeat (3) cycle();
        check_eq("t6_load_in_run", 32'(bcd_w == 16'h5555), 32'd0);
        i_load = 1'b0;
        repeat (4) cycle();
        #2 reset = 1'b1;
        #1;
        check_eq("t6_rst_bcd",     32'(bcd_w),   32'h0);
        check_eq("t6_rst_state",   32'(state_w), 32'd0);
        check_eq("t6_rst_running", 32'(run_w),   32'd0);
        model_reset();
        @(posedge clk);
        #1;
        reset = 1'b0;

        // Random phase
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 24) == 0) i_run = ~i_run;
            if ($urandom_range(0, 39) == 0) i_dir = ~i_dir;
            i_clear = ($urandom_range(0, 59) == 0);
            i_load  = ($urandom_range(0, 14) == 0);
            case ($urandom_range(0, 4))
                0:       i_load_val = 16'h9999;
                1:       i_load_val = 16'h0000;
                2:       i_load_val = 16'h9998;
                3:       i_load_val = 16'h0001;
                default: i_load_val = 16'($urandom);
            endcase
            cycle();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/bcd_updown_stopwatch.md
Name: bcd_updown_stopwatch

Overview:
Parametrised multi-digit BCD counter with integrated prescaler and run/stop/clear control FSM. Counts at TICK_HZ, up or down, with wrap or saturate at the terminal value, and synchronous preload while stopped. Sits between the switch/button front end and fnd_controller. It drives o_bcd directly as packed BCD digits, so no binary-to-BCD conversion is needed downstream.

Parameters:
CLK_HZ, 100_000_000, input clock frequency
TICK_HZ, 10, count rate; DIV = CLK_HZ/TICK_HZ, DIV >= 2 required (elaboration error otherwise)
NUM_DIGITS, 4, number of BCD digits, 1..8
WRAP, 1, 1 = wrap at terminal value, 0 = saturate

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high
i_run  in  1  level: 1 = run, 0 = stop (already synchronised/debounced)
i_clear  in  1  level: clear request
i_dir  in  1  0 = count up, 1 = count down
i_load  in  1  preload strobe, honoured only in STOP
i_load_val  in  4*NUM_DIGITS  preload value, packed BCD, digit 0 = LSBs
o_bcd  out  4*NUM_DIGITS  registered count, packed BCD
o_tick  out  1  one-cycle pulse, coincident with each count update
o_carry  out  1  one-cycle pulse on a tick taken while count is at terminal
o_running  out  1  1 while state == RUN
o_state  out  2  current FSM state encoding

Behaviour:
- Reset (async): state = STOP, prescaler = 0, o_bcd = 0, o_tick = 0, o_carry = 0, o_running = 0.
- FSM states: STOP = 2'd0, RUN = 2'd1, CLEAR = 2'd2. Encoding 2'd3 is illegal and returns to STOP on the next edge.
- FSM transitions are registered and evaluated every clk edge:
  - Any state, i_clear = 1 -> CLEAR. Clear has highest priority.
  - STOP, i_run = 1 -> RUN.
  - RUN, i_run = 0 -> STOP.
  - CLEAR, i_clear = 0 -> STOP, regardless of i_run. Run requires re-evaluation from STOP, so a minimum of 1 cycle is spent in STOP.
- Prescaler (0..DIV-1):
  - RUN: increments every cycle.
  - STOP: holds its value, so partial-period time is preserved across pause.
  - CLEAR: forced to 0.
- Tick: in RUN, at the edge where prescaler == DIV-1, prescaler <= 0, count <= next(count), and o_tick <= 1 for exactly one cycle. The first tick after entering RUN from a fresh clear arrives DIV cycles after the state becomes RUN.
- Count up: digit 0 increments. A digit at 9 becomes 0 and carries into the next digit.
- Count down: a digit at 0 becomes 9 and borrows from the next digit.
- Terminal value is all-9 when counting up and all-0 when counting down.
  - WRAP = 1: a tick at terminal wraps (all-9 -> all-0 up, all-0 -> all-9 down) and pulses o_carry.
  - WRAP = 0: a tick at terminal leaves the count unchanged and still pulses o_carry and o_tick.
- i_dir is sampled on the tick edge only. A direction change takes effect on the next tick and does not disturb the prescaler.
- CLEAR: o_bcd forced to 0 on every cycle in CLEAR. o_tick = 0 and o_carry = 0 in CLEAR.
- Load:
  - When state == STOP and i_load = 1, o_bcd <= i_load_val on that edge.
  - Any input digit > 9 is clamped to 9.
  - Load is ignored in RUN and CLEAR. If i_clear and i_load are both high in STOP, clear wins; load is ignored because the next state is CLEAR and o_bcd <= 0.
- o_running = (state == RUN), registered alongside state. o_state mirrors the state register.
- Reset asserted mid-count returns all outputs to their reset values immediately; the count is not retained.

Decomposition:
- Package stopwatch_pkg: state localparams (STOP/RUN/CLEAR), BCD_W = 4, digit max 4'd9, and function bcd_clamp(digit).
- Sub-module tick_gen (params DIV; ports clk, reset, en, clr, o_tick): the prescaler.
- The top instantiates tick_gen once and implements the digit chain with a generate loop over NUM_DIGITS. Each digit gets carry-in/borrow-in from the lower digit and produces carry-out/borrow-out.

Test Plan:
(All use CLK_HZ = 100, TICK_HZ = 10, so DIV = 10; NUM_DIGITS = 4, WRAP = 1.)
1. reset, then i_run = 1 for 35 cycles -> exactly 3 o_tick pulses, 10 cycles apart; o_bcd = 16'h0003; o_running = 1.
2. Pause/resume: run 15 cycles, i_run = 0 for 50 cycles, i_run = 1 -> o_bcd holds 0001 while stopped; next tick arrives 5 cycles after resume (prescaler preserved).
3. Wrap: load 16'h9998 in STOP, run up 2 ticks -> 9999, then 0000; o_carry pulses on the second tick only. Repeat with i_dir = 1 from 0001 -> 0000, 9999 with o_carry.
4. Saturate (WRAP = 0): load 9999, run up 3 ticks -> o_bcd stays 9999; 3 o_tick and 3 o_carry pulses.
5. Clear priority: i_clear = 1 while RUN at count 0042 -> state CLEAR next edge, o_bcd = 0, prescaler = 0. Release i_clear with i_run = 1 -> STOP for 1 cycle, then RUN; first tick DIV cycles later.
6. Load rules: i_load with value 16'h12A7 in STOP -> o_bcd = 16'h1297 (digit clamp); i_load in RUN -> ignored; reset asserted mid-count -> o_bcd = 0 and state = STOP asynchronously.
